// File: rtl/instr_seq_pkg.sv
// Shared constants for the instruction sequencer: opcode map, executor unit
// indices, FSM state encoding, instruction field positions and the opcode decoder.
package instr_seq_pkg;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned DST_MSB = 11;
  localparam int unsigned DST_LSB = 9;
  localparam int unsigned SRC_MSB = 8;
  localparam int unsigned SRC_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MOVI = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] U_MOVI = 2'd0;
  localparam logic [1:0] U_MOV  = 2'd1;
  localparam logic [1:0] U_ADD  = 2'd2;
  localparam logic [1:0] U_SUB  = 2'd3;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RETIRE = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;

  typedef enum logic [1:0] {
    DecExec,
    DecNop,
    DecHalt,
    DecIllegal
  } dec_kind_e;

  typedef struct packed {
    dec_kind_e  kind;
    logic [1:0] unit;
  } dec_t;

  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d.kind = DecIllegal;
    d.unit = U_MOVI;
    case (op)
      OP_MOVI: begin
        d.kind = DecExec;
        d.unit = U_MOVI;
      end
      OP_MOV: begin
        d.kind = DecExec;
        d.unit = U_MOV;
      end
      OP_ADD: begin
        d.kind = DecExec;
        d.unit = U_ADD;
      end
      OP_SUB: begin
        d.kind = DecExec;
        d.unit = U_SUB;
      end
      OP_NOP:  d.kind = DecNop;
      OP_HALT: d.kind = DecHalt;
      default: d.kind = DecIllegal;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exec_watchdog.sv
// Clear/enable cycle counter guarding executor completion; expired marks the
// enabled cycle in which the count reaches TIMEOUT_CYCLES.
module exec_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  // Saturates at LIMIT so a stalled enable can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Looks at the post-increment value so the FSM can leave on the last allowed cycle.
  assign expired = en && !clr && (count_d == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Top-level control FSM: fetch, decode, dispatch to one executor with a start
// pulse, wait for its done under a watchdog, then retire with a PC increment.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned IW             = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [IW-1:0]        instr_data,
  output logic                 instr_ready,
  output logic [IW-1:0]        ir_out,
  output logic [NUM_UNITS-1:0] exec_start,
  input  logic [NUM_UNITS-1:0] exec_done,
  output logic                 PC_inc,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout_err
);

  logic [2:0]           state_q, state_d;
  logic [IW-1:0]        ir_q, ir_d;
  logic [1:0]           unit_q, unit_d;
  logic [NUM_UNITS-1:0] exec_start_q, exec_start_d;
  logic                 pc_inc_q, pc_inc_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic                 wd_clr, wd_en, wd_expired;
  dec_t                 dec;

  assign dec = decode_op(ir_q[OPC_MSB:OPC_LSB]);

  exec_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  // Pulses are computed one state ahead so they appear registered in EXEC/RETIRE.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    unit_d       = unit_q;
    exec_start_d = '0;
    pc_inc_d     = 1'b0;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;

    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (dec.kind)
          DecExec: begin
            unit_d       = dec.unit;
            exec_start_d = NUM_UNITS'(1) << dec.unit;
            state_d      = EXEC;
          end
          DecNop: begin
            pc_inc_d = 1'b1;
            state_d  = RETIRE;
          end
          DecHalt: begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end
          default: begin
            halted_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = HALTED;
          end
        endcase
      end
      EXEC: begin
        wd_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        // Done wins over a timeout landing in the same cycle.
        if (exec_done[unit_q]) begin
          pc_inc_d = 1'b1;
          state_d  = RETIRE;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = HALTED;
        end
      end
      RETIRE: begin
        state_d = FETCH;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      ir_q         <= '0;
      unit_q       <= U_MOVI;
      exec_start_q <= '0;
      pc_inc_q     <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      unit_q       <= unit_d;
      exec_start_q <= exec_start_d;
      pc_inc_q     <= pc_inc_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
    end
  end

  assign instr_ready = (state_q == FETCH);
  assign busy        = (state_q != FETCH) && (state_q != HALTED);
  assign ir_out      = ir_q;
  assign exec_start  = exec_start_q;
  assign PC_inc      = pc_inc_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected start/retire events are queued
// when an instruction is issued and matched as the DUT pulses them.
module tb_instr_sequencer;

  localparam int NU = 4;
  localparam int TO = 16;
  localparam int IW = 16;

  localparam logic [31:0] EV_START  = 32'h100;
  localparam logic [31:0] EV_RETIRE = 32'h200;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instr_valid = 1'b0;
  logic [IW-1:0] instr_data = '0;
  logic          instr_ready;
  logic [IW-1:0] ir_out;
  logic [NU-1:0] exec_start;
  logic [NU-1:0] exec_done = '0;
  logic          PC_inc;
  logic          busy;
  logic          halted;
  logic          illegal;
  logic          timeout_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];

  instr_sequencer #(
    .NUM_UNITS     (NU),
    .TIMEOUT_CYCLES(TO),
    .IW            (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .instr_ready(instr_ready),
    .ir_out     (ir_out),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .PC_inc     (PC_inc),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_match(input logic [31:0] obs);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      check_eq("sb_unexpected", obs, 32'h0);
    end else begin
      exp = sb_q.pop_front();
      check_eq("sb_event", obs, exp);
    end
  endtask

  // Every start/retire pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (exec_start != '0) sb_match(EV_START | 32'(exec_start));
      if (PC_inc) sb_match(EV_RETIRE);
    end
  end

  task automatic check_reset_vals();
    check_eq("rst_ir", 32'(ir_out), 0);
    check_eq("rst_pulses", 32'({exec_start, PC_inc}), 0);
    check_eq("rst_flags", 32'({busy, halted, illegal, timeout_err}), 0);
    check_eq("rst_ready", 32'(instr_ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst         = 1'b0;
    instr_valid = 1'b0;
    exec_done   = '0;
    #1;
    check_reset_vals();
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at a FETCH negedge; returns at the DECODE negedge.
  task automatic issue(input logic [15:0] w);
    check_eq("fetch_ready", 32'(instr_ready), 1);
    instr_valid = 1'b1;
    instr_data  = w;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = 16'($urandom);
  endtask

  task automatic run_exec(input logic [15:0] w, input int unit, input int d,
                          input logic [3:0] noise, input bit early);
    logic [3:0] oh;
    oh = 4'(1) << unit;
    sb_q.push_back(EV_START | 32'(oh));
    sb_q.push_back(EV_RETIRE);
    issue(w);
    check_eq("dec_busy", 32'(busy), 1);
    check_eq("dec_ir", 32'(ir_out), 32'(w));
    @(negedge clk);
    check_eq("exec_start", 32'(exec_start), 32'(oh));
    check_eq("exec_ir", 32'(ir_out), 32'(w));
    exec_done = early ? oh : 4'h0;
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      check_eq("wait_no_pc", 32'({PC_inc, exec_start}), 0);
      check_eq("wait_busy", 32'(busy), 1);
      exec_done = (k == d) ? oh : (noise & ~oh);
    end
    @(negedge clk);
    exec_done = '0;
    check_eq("retire_pc", 32'(PC_inc), 1);
    check_eq("retire_ir", 32'(ir_out), 32'(w));
    @(negedge clk);
    check_eq("back_fetch", 32'({instr_ready, busy, PC_inc}), 32'b100);
  endtask

  task automatic run_nop();
    sb_q.push_back(EV_RETIRE);
    issue(16'h0000);
    check_eq("nop_dec_start", 32'(exec_start), 0);
    @(negedge clk);
    check_eq("nop_pc", 32'(PC_inc), 1);
    @(negedge clk);
    check_eq("nop_fetch", 32'(instr_ready), 1);
  endtask

  task automatic run_stop(input logic [15:0] w, input bit exp_illegal);
    issue(w);
    check_eq("stop_dec_busy", 32'(busy), 1);
    @(negedge clk);
    check_eq("stop_halted", 32'(halted), 1);
    check_eq("stop_illegal", 32'(illegal), 32'(exp_illegal));
    check_eq("stop_ready_busy_to", 32'({instr_ready, busy, timeout_err}), 0);
    instr_valid = 1'b1;
    instr_data  = 16'h7002;
    exec_done   = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("halt_sticky", 32'({halted, instr_ready}), 32'b10);
    end
    check_eq("halt_illegal_sticky", 32'(illegal), 32'(exp_illegal));
    instr_valid = 1'b0;
    exec_done   = '0;
  endtask

  task automatic run_timeout();
    sb_q.push_back(EV_START | 32'h1);
    issue(16'h7002);
    @(negedge clk);
    check_eq("to_start", 32'(exec_start), 1);
    exec_done = '0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check_eq("to_pending", 32'({halted, timeout_err}), 0);
    end
    @(negedge clk);
    check_eq("to_flags", 32'({timeout_err, halted, illegal}), 32'b110);
    check_eq("to_ready", 32'(instr_ready), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    do_reset();
    run_exec(16'h7002, 0, 2, 4'h0, 1'b0);
    run_exec(16'h7002, 0, 2, 4'h0, 1'b0);
    run_exec(16'h2203, 2, 3, 4'b1000, 1'b0);
    run_exec(16'h1a05, 1, 4, 4'b0101, 1'b1);
    run_exec(16'h3e7f, 3, 2, 4'b0111, 1'b0);
    run_nop();
    run_exec(16'h7155, 0, TO, 4'h0, 1'b0);
    check_eq("late_done_no_to", 32'({timeout_err, halted}), 0);

    run_stop(16'hF000, 1'b0);
    do_reset();
    run_stop(16'h5000, 1'b1);
    do_reset();
    run_stop(16'h8123, 1'b1);
    do_reset();
    run_timeout();
    do_reset();

    // Reset asserted mid-WAIT while done is already presented.
    sb_q.push_back(EV_START | 32'h8);
    issue(16'h3605);
    @(negedge clk);
    check_eq("mid_start", 32'(exec_start), 32'h8);
    @(negedge clk);
    exec_done = 4'h8;
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    exec_done = '0;
    rst = 1'b1;
    run_exec(16'h1234, 1, 1, 4'h0, 1'b0);

    check_eq("sb_empty", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
